// File: rtl/m_pkg.sv
// Shared M-extension definitions: mux select encodings, funct3 and res_sel codes,
// sequencer state enum and the restoring-divide iteration count.
package m_pkg;

    localparam int unsigned MUX_MULTA_LENGTH = 2;
    localparam int unsigned MUX_MULTB_LENGTH = 2;
    localparam int unsigned MUX_R_LENGTH     = 3;
    localparam int unsigned MUX_D_LENGTH     = 2;
    localparam int unsigned MUX_Z_LENGTH     = 2;
    localparam int unsigned RES_SEL_LENGTH   = 2;
    localparam int unsigned FUNCT3_LENGTH    = 3;

    localparam int unsigned DIV_ITERS        = 32;
    localparam int unsigned DIV_CNT_W        = 5;

    // Multiplier operand A selects
    localparam logic [MUX_MULTA_LENGTH-1:0] MULTA_ZERO       = MUX_MULTA_LENGTH'(0);
    localparam logic [MUX_MULTA_LENGTH-1:0] MULTA_R_SIGNED   = MUX_MULTA_LENGTH'(1);
    localparam logic [MUX_MULTA_LENGTH-1:0] MULTA_R_UNSIGNED = MUX_MULTA_LENGTH'(2);

    // Multiplier operand B selects
    localparam logic [MUX_MULTB_LENGTH-1:0] MULTB_ZERO       = MUX_MULTB_LENGTH'(0);
    localparam logic [MUX_MULTB_LENGTH-1:0] MULTB_D_SIGNED   = MUX_MULTB_LENGTH'(1);
    localparam logic [MUX_MULTB_LENGTH-1:0] MULTB_D_UNSIGNED = MUX_MULTB_LENGTH'(2);

    // R register selects
    localparam logic [MUX_R_LENGTH-1:0] R_KEEP       = MUX_R_LENGTH'(0);
    localparam logic [MUX_R_LENGTH-1:0] R_A          = MUX_R_LENGTH'(1);
    localparam logic [MUX_R_LENGTH-1:0] R_A_NEG      = MUX_R_LENGTH'(2);
    localparam logic [MUX_R_LENGTH-1:0] R_SUB_KEEP   = MUX_R_LENGTH'(3);
    localparam logic [MUX_R_LENGTH-1:0] R_MULT_LOWER = MUX_R_LENGTH'(4);

    // D register selects
    localparam logic [MUX_D_LENGTH-1:0] D_KEEP  = MUX_D_LENGTH'(0);
    localparam logic [MUX_D_LENGTH-1:0] D_B     = MUX_D_LENGTH'(1);
    localparam logic [MUX_D_LENGTH-1:0] D_B_NEG = MUX_D_LENGTH'(2);
    localparam logic [MUX_D_LENGTH-1:0] D_SHR   = MUX_D_LENGTH'(3);

    // Z register selects
    localparam logic [MUX_Z_LENGTH-1:0] Z_KEEP       = MUX_Z_LENGTH'(0);
    localparam logic [MUX_Z_LENGTH-1:0] Z_ZERO       = MUX_Z_LENGTH'(1);
    localparam logic [MUX_Z_LENGTH-1:0] Z_SHL_ADD    = MUX_Z_LENGTH'(2);
    localparam logic [MUX_Z_LENGTH-1:0] Z_MULT_UPPER = MUX_Z_LENGTH'(3);

    // Result stage source selects
    localparam logic [RES_SEL_LENGTH-1:0] RES_Z    = RES_SEL_LENGTH'(0);
    localparam logic [RES_SEL_LENGTH-1:0] RES_R    = RES_SEL_LENGTH'(1);
    localparam logic [RES_SEL_LENGTH-1:0] RES_ONES = RES_SEL_LENGTH'(2);

    // funct3 op codes
    localparam logic [FUNCT3_LENGTH-1:0] F3_MUL    = FUNCT3_LENGTH'(0);
    localparam logic [FUNCT3_LENGTH-1:0] F3_MULH   = FUNCT3_LENGTH'(1);
    localparam logic [FUNCT3_LENGTH-1:0] F3_MULHSU = FUNCT3_LENGTH'(2);
    localparam logic [FUNCT3_LENGTH-1:0] F3_MULHU  = FUNCT3_LENGTH'(3);
    localparam logic [FUNCT3_LENGTH-1:0] F3_DIV    = FUNCT3_LENGTH'(4);
    localparam logic [FUNCT3_LENGTH-1:0] F3_DIVU   = FUNCT3_LENGTH'(5);
    localparam logic [FUNCT3_LENGTH-1:0] F3_REM    = FUNCT3_LENGTH'(6);
    localparam logic [FUNCT3_LENGTH-1:0] F3_REMU   = FUNCT3_LENGTH'(7);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_MUL_OPS  = 3'd2,
        S_MUL_WAIT = 3'd3,
        S_MUL_WB   = 3'd4,
        S_DIV_ITER = 3'd5,
        S_DONE     = 3'd6
    } m_state_t;

    // Operation captured at acceptance
    typedef struct packed {
        logic [FUNCT3_LENGTH-1:0] funct3;
        logic                     rs1_sign;
        logic                     rs2_sign;
        logic                     rs2_zero;
    } m_op_t;

endpackage

// File: rtl/m_op_decode.sv
// Combinational funct3 decode into op class and operand signed-ness.
module m_op_decode
    import m_pkg::*;
(
    input  logic [2:0] funct3,
    output logic       is_div,
    output logic       is_rem,
    output logic       is_high,
    output logic       a_signed,
    output logic       b_signed
);

    // Class and signed-ness lookup
    always_comb begin
        is_div   = 1'b0;
        is_rem   = 1'b0;
        is_high  = 1'b0;
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3)
            F3_MUL: begin
            end
            F3_MULH: begin
                is_high  = 1'b1;
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            F3_MULHSU: begin
                is_high  = 1'b1;
                a_signed = 1'b1;
            end
            F3_MULHU: begin
                is_high  = 1'b1;
            end
            F3_DIV: begin
                is_div   = 1'b1;
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            F3_DIVU: begin
                is_div   = 1'b1;
            end
            F3_REM: begin
                is_div   = 1'b1;
                is_rem   = 1'b1;
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            default: begin
                is_div   = 1'b1;
                is_rem   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/m_control.sv
// M-extension sequencer: accepts a MUL/DIV-class op and drives the datapath
// register and multiplier selects state by state; all outputs are registered
// and aligned with the state they belong to.
// Optional feature: define M_DIV_ZERO_BYPASS_EN to short-circuit divide by zero
// straight from LOAD to DONE.
module m_control
    import m_pkg::*;
(
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        start,
    input  logic [2:0]                  funct3,
    input  logic                        rs1_sign,
    input  logic                        rs2_sign,
    input  logic                        rs2_zero,
    input  logic                        sub_neg,
    output logic                        busy,
    output logic                        done,
    output logic [MUX_MULTA_LENGTH-1:0] mux_multA,
    output logic [MUX_MULTB_LENGTH-1:0] mux_multB,
    output logic [MUX_R_LENGTH-1:0]     mux_R,
    output logic [MUX_D_LENGTH-1:0]     mux_D,
    output logic [MUX_Z_LENGTH-1:0]     mux_Z,
    output logic [1:0]                  res_sel,
    output logic                        neg_result
);

`ifdef M_DIV_ZERO_BYPASS_EN
    localparam bit ZERO_BYPASS = 1'b1;
`else
    localparam bit ZERO_BYPASS = 1'b0;
`endif

    m_state_t                    state_q, state_d;
    m_op_t                       op_q, op_d;
    logic [DIV_CNT_W-1:0]        cnt_q, cnt_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic [MUX_MULTA_LENGTH-1:0] mux_multa_q, mux_multa_d;
    logic [MUX_MULTB_LENGTH-1:0] mux_multb_q, mux_multb_d;
    logic [MUX_R_LENGTH-1:0]     mux_r_q, mux_r_d;
    logic [MUX_D_LENGTH-1:0]     mux_d_q, mux_d_d;
    logic [MUX_Z_LENGTH-1:0]     mux_z_q, mux_z_d;
    logic [RES_SEL_LENGTH-1:0]   res_sel_q, res_sel_d;
    logic                        neg_result_q, neg_result_d;

    logic dec_is_div;
    logic dec_is_rem;
    logic dec_is_high;
    logic dec_a_signed;
    logic dec_b_signed;
    logic zero_bypass;

    // sub_neg steers the datapath directly through SUB_KEEP; sequencing never looks at it
    logic unused_sub_neg;
    assign unused_sub_neg = sub_neg;

    // Capture the op only when a start is accepted in IDLE
    always_comb begin
        op_d = op_q;
        if ((state_q == S_IDLE) && start) begin
            op_d = '{funct3: funct3, rs1_sign: rs1_sign,
                     rs2_sign: rs2_sign, rs2_zero: rs2_zero};
        end
    end

    m_op_decode u_op_decode (
        .funct3   (op_d.funct3),
        .is_div   (dec_is_div),
        .is_rem   (dec_is_rem),
        .is_high  (dec_is_high),
        .a_signed (dec_a_signed),
        .b_signed (dec_b_signed)
    );

    assign zero_bypass = ZERO_BYPASS && dec_is_div && op_d.rs2_zero;

    // Next state, iteration counter, and outputs decoded from next state and op
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        mux_multa_d  = MULTA_ZERO;
        mux_multb_d  = MULTB_ZERO;
        mux_r_d      = R_KEEP;
        mux_d_d      = D_KEEP;
        mux_z_d      = Z_KEEP;
        res_sel_d    = RES_Z;
        neg_result_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d = '0;
                if (!dec_is_div) begin
                    state_d = S_MUL_OPS;
                end else if (zero_bypass) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DIV_ITER;
                end
            end
            S_MUL_OPS:  state_d = S_MUL_WAIT;
            S_MUL_WAIT: state_d = S_MUL_WB;
            S_MUL_WB:   state_d = S_DONE;
            S_DIV_ITER: begin
                if (cnt_q == DIV_CNT_W'(DIV_ITERS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);

        case (state_d)
            S_LOAD: begin
                mux_z_d = Z_ZERO;
                mux_r_d = (dec_is_div && dec_a_signed && op_d.rs1_sign && !zero_bypass)
                          ? R_A_NEG : R_A;
                mux_d_d = (dec_is_div && dec_b_signed && op_d.rs2_sign && !zero_bypass)
                          ? D_B_NEG : D_B;
            end
            S_MUL_OPS, S_MUL_WAIT: begin
                mux_multa_d = dec_a_signed ? MULTA_R_SIGNED : MULTA_R_UNSIGNED;
                mux_multb_d = dec_b_signed ? MULTB_D_SIGNED : MULTB_D_UNSIGNED;
            end
            S_MUL_WB: begin
                mux_multa_d = dec_a_signed ? MULTA_R_SIGNED : MULTA_R_UNSIGNED;
                mux_multb_d = dec_b_signed ? MULTB_D_SIGNED : MULTB_D_UNSIGNED;
                mux_r_d     = R_MULT_LOWER;
                mux_z_d     = Z_MULT_UPPER;
            end
            S_DIV_ITER: begin
                mux_r_d = R_SUB_KEEP;
                mux_z_d = Z_SHL_ADD;
                mux_d_d = D_SHR;
            end
            S_DONE: begin
                if (!dec_is_div) begin
                    res_sel_d = dec_is_high ? RES_Z : RES_R;
                end else if (zero_bypass) begin
                    res_sel_d = dec_is_rem ? RES_R : RES_ONES;
                end else if (dec_is_rem) begin
                    res_sel_d    = RES_R;
                    neg_result_d = dec_a_signed && op_d.rs1_sign;
                end else begin
                    res_sel_d    = RES_Z;
                    neg_result_d = dec_a_signed && (op_d.rs1_sign ^ op_d.rs2_sign)
                                   && !op_d.rs2_zero;
                end
            end
            default: begin
            end
        endcase
    end

    // State, op and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mux_multa_q  <= MULTA_ZERO;
            mux_multb_q  <= MULTB_ZERO;
            mux_r_q      <= R_KEEP;
            mux_d_q      <= D_KEEP;
            mux_z_q      <= Z_KEEP;
            res_sel_q    <= RES_Z;
            neg_result_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            mux_multa_q  <= mux_multa_d;
            mux_multb_q  <= mux_multb_d;
            mux_r_q      <= mux_r_d;
            mux_d_q      <= mux_d_d;
            mux_z_q      <= mux_z_d;
            res_sel_q    <= res_sel_d;
            neg_result_q <= neg_result_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign mux_multA  = mux_multa_q;
    assign mux_multB  = mux_multb_q;
    assign mux_R      = mux_r_q;
    assign mux_D      = mux_d_q;
    assign mux_Z      = mux_z_q;
    assign res_sel    = res_sel_q;
    assign neg_result = neg_result_q;

endmodule

// File: tb/tb_m_control.sv
// Directed, table-driven bench for the M-extension sequencer.
// Expectations follow M_DIV_ZERO_BYPASS_EN when it is defined for the build.
module tb_m_control;
    import m_pkg::*;

`ifdef M_DIV_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                        clk = 1'b0;
    logic                        resetn;
    logic                        start;
    logic [2:0]                  funct3;
    logic                        rs1_sign;
    logic                        rs2_sign;
    logic                        rs2_zero;
    logic                        sub_neg;
    logic                        busy;
    logic                        done;
    logic [MUX_MULTA_LENGTH-1:0] mux_multA;
    logic [MUX_MULTB_LENGTH-1:0] mux_multB;
    logic [MUX_R_LENGTH-1:0]     mux_R;
    logic [MUX_D_LENGTH-1:0]     mux_D;
    logic [MUX_Z_LENGTH-1:0]     mux_Z;
    logic [1:0]                  res_sel;
    logic                        neg_result;

    int n_cmp = 0;
    int n_bad = 0;

    m_control dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .funct3     (funct3),
        .rs1_sign   (rs1_sign),
        .rs2_sign   (rs2_sign),
        .rs2_zero   (rs2_zero),
        .sub_neg    (sub_neg),
        .busy       (busy),
        .done       (done),
        .mux_multA  (mux_multA),
        .mux_multB  (mux_multB),
        .mux_R      (mux_R),
        .mux_D      (mux_D),
        .mux_Z      (mux_Z),
        .res_sel    (res_sel),
        .neg_result (neg_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] f3;
        logic       s1;
        logic       s2;
        logic       z;
        int         lat;
        int         res;
        int         neg;
        int         ld_r;
        int         ld_d;
        int         t2_a;
        int         t2_b;
        int         t2_r;
    } vec_t;

    vec_t vecs[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},  int'(busy), 0);
        chk({tag, "_done"},  int'(done), 0);
        chk({tag, "_multA"}, int'(mux_multA), int'(MULTA_ZERO));
        chk({tag, "_multB"}, int'(mux_multB), int'(MULTB_ZERO));
        chk({tag, "_R"},     int'(mux_R), int'(R_KEEP));
        chk({tag, "_D"},     int'(mux_D), int'(D_KEEP));
        chk({tag, "_Z"},     int'(mux_Z), int'(Z_KEEP));
        chk({tag, "_res"},   int'(res_sel), int'(RES_Z));
        chk({tag, "_neg"},   int'(neg_result), 0);
    endtask

    // One op from acceptance through DONE and back to IDLE
    task automatic run_op(input vec_t v);
        int lat;
        lat = 0;
        funct3   = v.f3;
        rs1_sign = v.s1;
        rs2_sign = v.s2;
        rs2_zero = v.z;
        start    = 1'b1;
        step();
        start    = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 1) begin
                chk({v.name, "_load_busy"}, int'(busy), 1);
                chk({v.name, "_load_R"}, int'(mux_R), v.ld_r);
                chk({v.name, "_load_D"}, int'(mux_D), v.ld_d);
                chk({v.name, "_load_Z"}, int'(mux_Z), int'(Z_ZERO));
            end
            if (c == 2) begin
                chk({v.name, "_t2_multA"}, int'(mux_multA), v.t2_a);
                chk({v.name, "_t2_multB"}, int'(mux_multB), v.t2_b);
                chk({v.name, "_t2_R"}, int'(mux_R), v.t2_r);
            end
            if (done) begin
                lat = c;
                chk({v.name, "_done_busy"}, int'(busy), 1);
                chk({v.name, "_res_sel"}, int'(res_sel), v.res);
                chk({v.name, "_neg"}, int'(neg_result), v.neg);
                break;
            end
            step();
        end
        chk({v.name, "_latency"}, lat, v.lat);
        step();
        chk({v.name, "_after_busy"}, int'(busy), 0);
        chk({v.name, "_after_done"}, int'(done), 0);
    endtask

    function automatic vec_t mk(input string name, input logic [2:0] f3, input logic s1,
                                input logic s2, input logic z, input int lat, input int res,
                                input int neg, input int ld_r, input int ld_d,
                                input int t2_a, input int t2_b, input int t2_r);
        vec_t v;
        v.name = name; v.f3 = f3; v.s1 = s1; v.s2 = s2; v.z = z;
        v.lat = lat; v.res = res; v.neg = neg; v.ld_r = ld_r; v.ld_d = ld_d;
        v.t2_a = t2_a; v.t2_b = t2_b; v.t2_r = t2_r;
        return v;
    endfunction

    initial begin
        int dones;
        int lat;
        int a0, b0, ru, rs, ka, kz, sk, an, bn, rk;
        a0 = int'(MULTA_ZERO); b0 = int'(MULTB_ZERO);
        an = int'(R_A_NEG); bn = int'(D_B_NEG);
        ru = int'(R_A); rs = int'(D_B);
        ka = int'(MULTA_R_SIGNED); kz = int'(MULTA_R_UNSIGNED);
        sk = int'(R_SUB_KEEP); rk = int'(R_KEEP);

        //                name        f3         s1    s2    z     lat              res                             neg        ld_r             ld_d  t2_a  t2_b                        t2_r
        vecs[0]  = mk("mul",    F3_MUL,    1'b1, 1'b1, 1'b0, 5, int'(RES_R), 0, ru, rs, kz, int'(MULTB_D_UNSIGNED), rk);
        vecs[1]  = mk("mulh",   F3_MULH,   1'b1, 1'b0, 1'b0, 5, int'(RES_Z), 0, ru, rs, ka, int'(MULTB_D_SIGNED),   rk);
        vecs[2]  = mk("mulhsu", F3_MULHSU, 1'b1, 1'b1, 1'b0, 5, int'(RES_Z), 0, ru, rs, ka, int'(MULTB_D_UNSIGNED), rk);
        vecs[3]  = mk("mulhu",  F3_MULHU,  1'b0, 1'b0, 1'b0, 5, int'(RES_Z), 0, ru, rs, kz, int'(MULTB_D_UNSIGNED), rk);
        vecs[4]  = mk("div_n_p",  F3_DIV,  1'b1, 1'b0, 1'b0, 34, int'(RES_Z), 1, an, rs, a0, b0, sk);
        vecs[5]  = mk("div_n_n",  F3_DIV,  1'b1, 1'b1, 1'b0, 34, int'(RES_Z), 0, an, bn, a0, b0, sk);
        vecs[6]  = mk("divu",     F3_DIVU, 1'b1, 1'b0, 1'b0, 34, int'(RES_Z), 0, ru, rs, a0, b0, sk);
        vecs[7]  = mk("rem_n_n",  F3_REM,  1'b1, 1'b1, 1'b0, 34, int'(RES_R), 1, an, bn, a0, b0, sk);
        vecs[8]  = mk("remu_n_n", F3_REMU, 1'b1, 1'b1, 1'b0, 34, int'(RES_R), 0, ru, rs, a0, b0, sk);
        vecs[9]  = mk("divu_z",   F3_DIVU, 1'b0, 1'b0, 1'b1, BYP ? 2 : 34,
                      BYP ? int'(RES_ONES) : int'(RES_Z), 0, ru, rs, a0, b0, BYP ? rk : sk);
        vecs[10] = mk("div_z",    F3_DIV,  1'b1, 1'b0, 1'b1, BYP ? 2 : 34,
                      BYP ? int'(RES_ONES) : int'(RES_Z), 0, BYP ? ru : an, rs, a0, b0, BYP ? rk : sk);
        vecs[11] = mk("rem_z",    F3_REM,  1'b1, 1'b0, 1'b1, BYP ? 2 : 34,
                      int'(RES_R), BYP ? 0 : 1, BYP ? ru : an, rs, a0, b0, BYP ? rk : sk);
        vecs[12] = mk("rem_p_n",  F3_REM,  1'b0, 1'b1, 1'b0, 34, int'(RES_R), 0, ru, bn, a0, b0, sk);

        resetn = 1'b0; start = 1'b0; funct3 = 3'd0;
        rs1_sign = 1'b0; rs2_sign = 1'b0; rs2_zero = 1'b0; sub_neg = 1'b0;
        step(); step(); step();
        chk_idle_outputs("reset");
        resetn = 1'b1;
        step();
        chk_idle_outputs("post_reset");

        for (int i = 0; i < 13; i++) begin
            sub_neg = 1'(i & 1);
            run_op(vecs[i]);
        end

        // start held high through a DIV; later changes to the op inputs must be ignored
        funct3 = F3_DIV; rs1_sign = 1'b1; rs2_sign = 1'b0; rs2_zero = 1'b0;
        start = 1'b1;
        step();
        rs1_sign = 1'b0; funct3 = F3_MUL;
        dones = 0; lat = 0;
        for (int c = 1; c <= 60; c++) begin
            if (done) begin
                dones++;
                lat = c;
                chk("held_res_sel", int'(res_sel), int'(RES_Z));
                chk("held_neg", int'(neg_result), 1);
                break;
            end
            step();
        end
        chk("held_latency", lat, 34);
        funct3 = F3_MULHU;
        step();
        if (done) dones++;
        chk("held_idle_busy", int'(busy), 0);
        chk("held_done_count", dones, 1);
        step();
        start = 1'b0;
        chk("held_reaccept_busy", int'(busy), 1);
        chk("held_reaccept_Z", int'(mux_Z), int'(Z_ZERO));
        step();
        chk("held_reaccept_multA", int'(mux_multA), int'(MULTA_R_UNSIGNED));
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk_idle_outputs("held_cleanup");

        // Reset abort at iteration 10 of a DIV
        funct3 = F3_DIV; rs1_sign = 1'b1; rs2_sign = 1'b1; rs2_zero = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 11; i++) step();
        chk("abort_pre_busy", int'(busy), 1);
        chk("abort_pre_R", int'(mux_R), int'(R_SUB_KEEP));
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk_idle_outputs("abort");
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (done || busy) dones++;
        end
        chk("abort_no_done", dones, 0);
        run_op(vecs[4]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/m_control.md
# m_control

Sequencing FSM for the M-extension unit: decodes a MUL/DIV-class funct3, then drives the multiplexer selects of the M datapath register block cycle by cycle. For multiplies it runs a fixed four-state pass through the multiplier. For divides it runs 32 restoring iterations. It tells the result stage which register to take and whether to negate it. It sits between the decode/issue handshake and the datapath registers.

## Interface
- No parameters; all widths come from the shared M definitions.
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- start  in  1  request; accepted only in IDLE
- funct3  in  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_sign, rs2_sign  in  1  operand bit 31, sampled with start
- rs2_zero  in  1  divisor == 0, sampled with start
- sub_neg  in  1  subtractor result negative (R < D)
- busy  out  1  high from the cycle after acceptance through DONE
- done  out  1  one-cycle pulse; result is valid in the same cycle
- mux_multA / mux_multB  out  MUX_MULTA/B_LENGTH  multiplier operand selects
- mux_R / mux_D / mux_Z  out  MUX_R/D/Z_LENGTH  datapath register selects
- res_sel  out  2  0 Z, 1 R, 2 all-ones
- neg_result  out  1  result stage two's-complements the selected value

## Operation
- start is sampled while in IDLE. On acceptance, register funct3, the sign bits and rs2_zero. start is ignored in every other state.
- Signed-ness:
  - DIV/REM: both operands are signed.
  - MULH: both operands are signed.
  - MULHSU: rs1 is signed, rs2 is unsigned.
- States and transitions:
  - IDLE → LOAD on start.
  - LOAD: mux_Z=ZERO.
    - mux_R=A_NEG if (DIV/REM and rs1_sign), else A.
    - mux_D=B_NEG if (DIV/REM and rs2_sign), else B.
    - MUL class → MUL_OPS; DIV class → DIV_ITER.
  - MUL_OPS, MUL_WAIT: mux_multA = R_SIGNED or R_UNSIGNED; mux_multB = D_SIGNED or D_UNSIGNED, both per signed-ness. R, D and Z keep. Transitions MUL_OPS → MUL_WAIT → MUL_WB.
  - MUL_WB: mux_R=MULT_LOWER, mux_Z=MULT_UPPER. Multiplier selects stay held so the datapath picks the signed upper-word form. → DONE.
  - DIV_ITER: mux_R=SUB_KEEP, mux_Z=SHL_ADD, mux_D=SHR. A 5-bit counter runs 0..31; the state exits to DONE after count 31.
  - DONE: done=1, busy=1. → IDLE.
- Outside the active states: multiplier selects are ZERO; R, D and Z selects are KEEP.
- res_sel / neg_result in DONE:
  - MUL: R, neg 0.
  - MULH*: Z, neg 0.
  - DIV/DIVU: Z, neg = signed & (rs1_sign ^ rs2_sign) & !rs2_zero.
  - REM/REMU: R, neg = signed & rs1_sign.
- Divide by zero with no bypass runs the iterations normally. The quotient comes out all-ones and the remainder equals the dividend. Overflow (-2^31 / -1) needs no special case.

## Timing
- Reset values of all outputs: busy 0, done 0, res_sel 0, neg_result 0, multiplier selects ZERO, R/D/Z selects KEEP. State is IDLE and the counter is 0.
- Start is accepted at edge t. Then:
  - LOAD occupies cycle t+1.
  - MUL: done in cycle t+5.
  - DIV: done in cycle t+34.
- A new start is accepted in the cycle after DONE at the earliest.
- Outputs are decoded from state and the registered op only. sub_neg has no combinational effect on any output.
- resetn low in any state: next edge goes to IDLE with reset outputs. No done is emitted for the aborted op.

## Configuration
- M_DIV_ZERO_BYPASS_EN. Applies only when an accepted DIV-class op has rs2_zero set:
  - Defined: LOAD uses mux_R=A, no negation. LOAD then goes directly to DONE, so done arrives at t+2.
    - DIV/DIVU: res_sel=all-ones.
    - REM/REMU: res_sel=R.
    - neg_result=0.
  - Undefined: the 32-iteration path is used; results are identical, latency is t+34.

## Structure
- The shared M definitions hold the mux select encodings, the funct3 codes, and the res_sel codes.
- The state enum and the DIV_ITERS=32 constant go into the shared package m_pkg.
- One sub-module, m_op_decode, is natural. It is combinational and maps funct3 to is_div, is_rem, is_high, a_signed and b_signed.

## Test plan
- MULHU, start at t: selects LOAD(A,B,ZERO) at t+1; UNSIGNED at t+2/t+3; MULT_UPPER at t+4; done at t+5 with res_sel Z, neg 0.
- DIV with rs1_sign=1, rs2_sign=0 (-7/2): LOAD mux_R=A_NEG, mux_D=B; exactly 32 DIV_ITER cycles; done at t+34 with res_sel Z, neg_result 1.
- REM with rs1_sign=1, rs2_sign=1 (-7/-2): res_sel R, neg_result 1. Repeat as REMU with the same signs: neg_result 0.
- DIVU with rs2_zero: with the macro, done at t+2 and res_sel all-ones. Without it, done at t+34, res_sel Z, neg 0.
- Assert start every cycle during a DIV: exactly one done, and the next acceptance happens the cycle after done.
- Drop resetn at iteration 10: IDLE next cycle, busy 0, no done pulse, counter 0.
